// File: rtl/exception_vector_fetch.sv
`default_nettype none
// ============================================================================
// exception_vector_fetch : fetches the exception handler byte from vector
// memory and issues the EPC/PC load strobes.      Revision: 1.0
// ============================================================================
module exception_vector_fetch #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  src_addr_sel,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] pc_out,
  output logic        pc_write,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ADDR    = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] CODE_RSVD = 2'b11;
  localparam logic [2:0] CNT_LOAD  = 3'(MEM_LATENCY);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_q, pc_d;

  // Only the low byte of the vector location is the handler address.
  logic w_unused_mem_hi;
  assign w_unused_mem_hi = &{1'b0, mem_data_in[31:8]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    epc_d   = epc_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (exc_req && (exc_code != CODE_RSVD)) begin
          sel_d   = {1'b0, exc_code} + 3'd1;
          epc_d   = pc_in - 32'd4;
          cnt_d   = CNT_LOAD;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == 3'd0) begin
          pc_d    = {24'b0, mem_data_in[7:0]};
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sel_q   <= 3'd0;
      epc_q   <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      epc_q   <= epc_d;
      pc_q    <= pc_d;
    end
  end

  // Select is gated by state so the mux returns to the normal path outside ADDR.
  assign src_addr_sel = (state_q == S_ADDR) ? sel_q : 3'b000;
  assign epc_out      = epc_q;
  assign pc_out       = pc_q;
  assign epc_write    = (state_q == S_WRITE);
  assign pc_write     = (state_q == S_WRITE);
  assign done         = (state_q == S_WRITE);
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
